// File: rtl/panel_serial_pkg.sv
// Shared types for the panel 74LV595 serialiser: FSM states, lane geometry
// and the mapping of panel fields onto the four 16-bit lanes.
package panel_serial_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 16;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_LO,
    ST_LATCH_HI
  } state_t;

  function automatic lanes_t pack_lanes(input logic [30:0] reg_c,
                                        input logic [5:0]  op,
                                        input logic [11:0] strt,
                                        input logic [11:0] sel);
    lanes_t l;
    l[0] = reg_c[15:0];
    l[1] = {1'b0, reg_c[30:16]};
    l[2] = {strt[3:0], sel};
    l[3] = {2'b00, op, strt[11:4]};
    return l;
  endfunction

endpackage

// File: rtl/panel_serial_out_timer.sv
// Phase timer: reloads to CLK_DIV-1 on restart and counts down; tick marks
// the last cycle of the current SRCLK/RCLK phase.
module serial_phase_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart)
      cnt_d = RELOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/panel_serial_out.sv
// Serialises the panel display fields onto four lanes of cascaded 74LV595s,
// generating SRCLK/RCLK; re-sends on data change, after reset, or on refresh.
module panel_serial_out
  import panel_serial_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [30:0] pnl_reg_c_value,
  input  logic [5:0]  pnl_op_code,
  input  logic [11:0] pnl_strt_value,
  input  logic [11:0] pnl_sel_value,
  output logic        serial_out_srclk,
  output logic        serial_out_rclk,
  output logic        serial_out_ser_0,
  output logic        serial_out_ser_1,
  output logic        serial_out_ser_2,
  output logic        serial_out_ser_3,
  output logic        serial_out_busy,
  output logic        serial_out_done
);

  localparam logic        REFR_EN  = (REFRESH_CYCLES != 0);
  localparam logic [31:0] REFR_MAX = (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);

  state_t      state_q, state_d;
  lanes_t      snap_q, snap_d;
  lanes_t      shreg_q, shreg_d;
  logic [3:0]  bit_q, bit_d;
  logic        force_q, force_d;
  logic [31:0] refr_q, refr_d;
  logic        srclk_q, srclk_d;
  logic        rclk_q, rclk_d;
  logic [3:0]  ser_q, ser_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  lanes_t packed_in;
  logic   trigger;
  logic   timer_restart;
  logic   phase_tick;

  assign packed_in = pack_lanes(pnl_reg_c_value, pnl_op_code, pnl_strt_value, pnl_sel_value);
  assign trigger   = (packed_in != snap_q) || force_q || (REFR_EN && (refr_q == REFR_MAX));

  serial_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (resetn),
    .restart (timer_restart),
    .tick    (phase_tick)
  );

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    shreg_d       = shreg_q;
    bit_d         = bit_q;
    force_d       = force_q;
    refr_d        = refr_q;
    ser_d         = ser_q;
    done_d        = 1'b0;
    timer_restart = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (refr_q != REFR_MAX)
          refr_d = refr_q + 32'd1;
        if (trigger)
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        snap_d        = packed_in;
        shreg_d       = packed_in;
        bit_d         = 4'd15;
        force_d       = 1'b0;
        refr_d        = '0;
        timer_restart = 1'b1;
        state_d       = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (phase_tick) begin
          timer_restart = 1'b1;
          state_d       = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_tick) begin
          timer_restart = 1'b1;
          shreg_d = {shreg_q[3][14:0], 1'b0, shreg_q[2][14:0], 1'b0,
                     shreg_q[1][14:0], 1'b0, shreg_q[0][14:0], 1'b0};
          if (bit_q == 4'd0) begin
            state_d = ST_LATCH_LO;
          end else begin
            bit_d   = bit_q - 4'd1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_LATCH_LO: begin
        if (phase_tick) begin
          timer_restart = 1'b1;
          state_d       = ST_LATCH_HI;
        end
      end
      ST_LATCH_HI: begin
        if (phase_tick) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    if ((state_d == ST_SHIFT_LO) && (state_q != ST_SHIFT_LO))
      ser_d = {shreg_d[3][15], shreg_d[2][15], shreg_d[1][15], shreg_d[0][15]};
    srclk_d = (state_d == ST_SHIFT_HI);
    rclk_d  = (state_d == ST_LATCH_HI);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      force_q <= 1'b1;
      refr_q  <= '0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      ser_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      force_q <= force_d;
      refr_q  <= refr_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign serial_out_srclk = srclk_q;
  assign serial_out_rclk  = rclk_q;
  assign serial_out_ser_0 = ser_q[0];
  assign serial_out_ser_1 = ser_q[1];
  assign serial_out_ser_2 = ser_q[2];
  assign serial_out_ser_3 = ser_q[3];
  assign serial_out_busy  = busy_q;
  assign serial_out_done  = done_q;

endmodule

// File: tb/tb_panel_serial_out.sv
// Bench for panel_serial_out: four instances (CLK_DIV 2/2/1/7, one with refresh),
// a 595 chain model per lane and a scoreboard of expected latched lane contents.
module tb_panel_serial_out;

  typedef struct {
    logic [30:0] reg_c;
    logic [5:0]  op;
    logic [11:0] strt;
    logic [11:0] sel;
    logic [63:0] lanes;   // {lane3, lane2, lane1, lane0}
  } vec_t;

  typedef struct {
    int          inst;
    logic [63:0] lanes;
  } sb_t;

  localparam int unsigned DIV [4] = '{2, 2, 1, 7};
  localparam int unsigned REF [4] = '{0, 100, 0, 0};

  logic        clk = 1'b0;
  logic [3:0]  rstn;
  logic [30:0] reg_c [4];
  logic [5:0]  op    [4];
  logic [11:0] strt  [4];
  logic [11:0] sel   [4];
  logic        srclk [4];
  logic        rclk  [4];
  logic        busy  [4];
  logic        done  [4];
  logic [3:0]  ser   [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic s0, s1, s2, s3;
    panel_serial_out #(.CLK_DIV(DIV[g]), .REFRESH_CYCLES(REF[g])) u_dut (
      .clk              (clk),
      .resetn           (rstn[g]),
      .pnl_reg_c_value  (reg_c[g]),
      .pnl_op_code      (op[g]),
      .pnl_strt_value   (strt[g]),
      .pnl_sel_value    (sel[g]),
      .serial_out_srclk (srclk[g]),
      .serial_out_rclk  (rclk[g]),
      .serial_out_ser_0 (s0),
      .serial_out_ser_1 (s1),
      .serial_out_ser_2 (s2),
      .serial_out_ser_3 (s3),
      .serial_out_busy  (busy[g]),
      .serial_out_done  (done[g])
    );
    assign ser[g] = {s3, s2, s1, s0};
  end

  logic [15:0] sr  [4][4];
  logic [63:0] lat [4];
  logic        p_srclk [4];
  logic        p_rclk  [4];
  logic        p_busy  [4];
  logic [3:0]  p_ser   [4];
  int busy_run [4], idle_run [4], rises [4], rpulses [4], frames [4];
  int last_len [4], last_rises [4], last_rclk [4], last_gap [4], last_start [4], prev_start [4];
  int cyc, n_chk, n_fail, v_ser, v_overlap, v_early, v_done;
  sb_t sb_q [$];
  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of monitoring: 595 chain model, frame statistics, scoreboard.
  task automatic step();
    sb_t e;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (!rstn[k]) begin
        p_srclk[k] = 1'b0; p_rclk[k] = 1'b0; p_busy[k] = 1'b0; p_ser[k] = ser[k];
        busy_run[k] = 0; rises[k] = 0; rpulses[k] = 0;
        continue;
      end
      if (srclk[k] && rclk[k]) v_overlap++;
      if (srclk[k]) begin
        if (ser[k] !== p_ser[k]) v_ser++;
        if (!p_srclk[k]) begin
          for (int l = 0; l < 4; l++) sr[k][l] = {sr[k][l][14:0], ser[k][l]};
          rises[k]++;
        end
      end
      if (rclk[k] && !p_rclk[k]) begin
        if (rises[k] != 16) v_early++;
        lat[k] = {sr[k][3], sr[k][2], sr[k][1], sr[k][0]};
        rpulses[k]++;
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_unexpected_latch: inst %0d latched %0h with nothing expected", k, lat[k]);
        end else begin
          e = sb_q.pop_front();
          chk("sb_inst", 64'(k), 64'(e.inst));
          chk("sb_lanes", lat[k], e.lanes);
        end
      end
      if (busy[k]) begin
        if (!p_busy[k]) begin
          prev_start[k] = last_start[k]; last_start[k] = cyc;
          last_gap[k] = idle_run[k]; busy_run[k] = 0; rises[k] = 0; rpulses[k] = 0;
        end
        busy_run[k]++;
      end else begin
        if (p_busy[k]) begin
          last_len[k] = busy_run[k]; last_rises[k] = rises[k]; last_rclk[k] = rpulses[k];
          frames[k]++; idle_run[k] = 0;
        end
        idle_run[k]++;
      end
      if (done[k] !== (p_busy[k] && !busy[k])) v_done++;
      p_srclk[k] = srclk[k]; p_rclk[k] = rclk[k]; p_busy[k] = busy[k]; p_ser[k] = ser[k];
    end
  endtask

  task automatic wait_frames(input int k, input int target, input int budget);
    int n = 0;
    while (frames[k] < target && n < budget) begin step(); n++; end
    chk("frame_reached", 64'(frames[k]), 64'(target));
  endtask

  task automatic wait_rises(input int k, input int target, input int budget);
    int n = 0;
    while (rises[k] != target && n < budget) begin step(); n++; end
    chk("rise_reached", 64'(rises[k]), 64'(target));
  endtask

  task automatic set_in(input int k, input vec_t v);
    reg_c[k] = v.reg_c; op[k] = v.op; strt[k] = v.strt; sel[k] = v.sel;
  endtask

  task automatic chk_decode(input int k, input vec_t v);
    logic [63:0] w;
    w = lat[k];
    chk("dec_reg_c", 64'({w[30:16], w[15:0]}), 64'(v.reg_c));
    chk("dec_op",    64'(w[61:56]), 64'(v.op));
    chk("dec_strt",  64'({w[55:48], w[47:44]}), 64'(v.strt));
    chk("dec_sel",   64'(w[43:32]), 64'(v.sel));
    chk("dec_pad",   64'({w[31], w[63:62]}), 64'd0);
  endtask

  task automatic chk_frame(input int k, input int len);
    chk("frame_len",   64'(last_len[k]), 64'(len));
    chk("frame_rises", 64'(last_rises[k]), 64'd16);
    chk("frame_rclk",  64'(last_rclk[k]), 64'd1);
  endtask

  initial begin
    vec_t vb, vb2, vz;
    vecs[0] = '{31'h5A5A_1234, 6'h2B, 12'hABC, 12'h123, 64'h2BAB_C123_5A5A_1234};
    vecs[1] = '{31'h7FFF_FFFF, 6'h3F, 12'hFFF, 12'hFFF, 64'h3FFF_FFFF_7FFF_FFFF};
    vecs[2] = '{31'h4000_8001, 6'h01, 12'h801, 12'h800, 64'h0180_1800_4000_8001};
    vz  = '{31'h0, 6'h0, 12'h0, 12'h0, 64'h0};
    vb  = vecs[0];
    vb2 = '{31'h5A5A_1234, 6'h2B, 12'hABC, 12'h456, 64'h2BAB_C456_5A5A_1234};

    rstn = '0;
    cyc = 0; n_chk = 0; n_fail = 0; v_ser = 0; v_overlap = 0; v_early = 0; v_done = 0;
    for (int k = 0; k < 4; k++) begin
      lat[k] = '0; p_srclk[k] = 0; p_rclk[k] = 0; p_busy[k] = 0; p_ser[k] = '0;
      busy_run[k] = 0; idle_run[k] = 0; rises[k] = 0; rpulses[k] = 0; frames[k] = 0;
      last_len[k] = 0; last_rises[k] = 0; last_rclk[k] = 0; last_gap[k] = 0;
      last_start[k] = 0; prev_start[k] = 0;
      for (int l = 0; l < 4; l++) sr[k][l] = '0;
    end
    set_in(0, vz);
    set_in(1, vecs[0]);
    set_in(2, vecs[2]);
    set_in(3, vecs[1]);

    repeat (3) step();
    chk("reset_outputs", 64'({srclk[0], rclk[0], ser[0], busy[0], done[0]}), 64'd0);

    // First frame straight after reset, all-zero inputs.
    sb_q.push_back('{0, 64'h0});
    rstn[0] = 1'b1;
    step();
    chk("first_frame_starts", 64'(busy[0]), 64'd1);
    wait_frames(0, 1, 200);
    chk_frame(0, 69);

    for (int i = 0; i < 3; i++) begin
      set_in(0, vecs[i]);
      sb_q.push_back('{0, vecs[i].lanes});
      wait_frames(0, frames[0] + 1, 300);
      chk_frame(0, 69);
      chk_decode(0, vecs[i]);
    end

    // sel changes while bit 8 is on the wire: current frame keeps old value.
    set_in(0, vb);
    sb_q.push_back('{0, vb.lanes});
    wait_rises(0, 7, 300);
    set_in(0, vb2);
    sb_q.push_back('{0, vb2.lanes});
    wait_frames(0, frames[0] + 1, 300);
    chk_decode(0, vb);
    wait_frames(0, frames[0] + 1, 300);
    chk("one_idle_between", 64'(last_gap[0]), 64'd1);
    chk_decode(0, vb2);

    // Asynchronous reset during bit 5, all-ones data so ser is high.
    set_in(0, vecs[1]);
    sb_q.push_back('{0, vecs[1].lanes});
    wait_rises(0, 11, 300);
    chk("pre_reset_active", 64'({srclk[0], busy[0], ser[0]}), 64'h3F);
    #2 rstn[0] = 1'b0;
    #1 chk("async_reset_outs", 64'({srclk[0], rclk[0], ser[0], busy[0]}), 64'd0);
    step(); step();
    rstn[0] = 1'b1;
    wait_frames(0, frames[0] + 1, 300);
    chk_frame(0, 69);
    chk_decode(0, vecs[1]);

    // Periodic refresh with constant inputs.
    repeat (3) sb_q.push_back('{1, vecs[0].lanes});
    rstn[1] = 1'b1;
    wait_frames(1, 1, 300);
    chk_frame(1, 69);
    wait_frames(1, 2, 400);
    chk("refresh_gap", 64'(last_gap[1]), 64'd100);
    chk("refresh_period", 64'(last_start[1] - prev_start[1]), 64'd169);
    wait_frames(1, 3, 400);
    chk("refresh_period2", 64'(last_start[1] - prev_start[1]), 64'd169);
    chk_decode(1, vecs[0]);
    rstn[1] = 1'b0;

    // CLK_DIV extremes.
    sb_q.push_back('{2, vecs[2].lanes});
    rstn[2] = 1'b1;
    wait_frames(2, 1, 200);
    chk_frame(2, 35);
    chk_decode(2, vecs[2]);
    rstn[2] = 1'b0;

    sb_q.push_back('{3, vecs[1].lanes});
    rstn[3] = 1'b1;
    wait_frames(3, 1, 600);
    chk_frame(3, 239);
    chk_decode(3, vecs[1]);
    rstn[3] = 1'b0;

    repeat (5) step();
    chk("ser_stable_at_srclk", 64'(v_ser), 64'd0);
    chk("srclk_rclk_overlap", 64'(v_overlap), 64'd0);
    chk("rclk_before_16_shifts", 64'(v_early), 64'd0);
    chk("done_pulse_timing", 64'(v_done), 64'd0);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
